sonar_rx_decoder: RTL
=====================

// Module: sonar_rx_decoder
// PURPOSE
//  Receives the sonar's serial telemetry line, deserialises 7O1 UART characters and parses "AAA,DDD#"
//  messages (3 ASCII angle digits, comma, 3 ASCII distance digits, '#').
//  Presents the last valid angle/distance pair as BCD, with a one-cycle pronto pulse.
//  Sits downstream of the sonar top-level's saida_serial output, on the receiving board or in loopback.
// PARAMETERS
//  CLK_DIV    434  clock cycles per bit (50 MHz / 115200 baud)
//  SYNC_STAGES  2  flip-flops in the rx input synchroniser (minimum 2)
// PORTS
//  clock         in   1   system clock, rising edge
//  reset         in   1   asynchronous, active-high; clears all state
//  entrada_serial in  1   UART line, idle high
//  angulo        out 12   BCD {centena,dezena,unidade} of last valid message
//  distancia     out 12   BCD {centena,dezena,unidade} of last valid message
//  pronto        out  1   1-cycle pulse: angulo/distancia just updated
//  erro          out  1   1-cycle pulse: framing/parity/format error
//  db_estado     out  4   parser state code
//  db_estado_rx  out  4   receiver state code
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset: angulo=0, distancia=0, pronto=0, erro=0, both FSMs idle, synchroniser chain set to 1.
//  RX FSM (rx_serial_7o1): IDLE, START, DADOS, PARIDADE, STOP.
//   - IDLE: a synchronised 1->0 edge starts a bit counter.
//   - START: at CLK_DIV/2 the line is resampled; if it is high (false start), return to IDLE with no erro.
//   - DADOS: 7 data bits sampled LSB-first every CLK_DIV cycles at mid-bit.
//   - PARIDADE: parity bit sampled. Parity is odd: data plus parity contain an odd number of 1s.
//   - STOP: stop sampled. Stop=0 is a framing error: byte dropped, erro pulses, FSM waits for the line high, then IDLE.
//   - Good byte: byte_valido pulses 1 cycle at the stop-bit mid sample; dado[6:0] holds until the next byte.
//  Parser FSM states (db_estado): IDLE=0 A2=1 A1=2 A0=3 VIRG=4 D2=5 D1=6 D0=7 HASH=8 RESYNC=F.
//   - IDLE expects an angle hundreds digit ('0'..'9', 0x30-0x39).
//   - A*/D* store (dado-0x30) into shadow registers; VIRG expects 0x2C; HASH expects 0x23.
//   - Unexpected byte in any state: erro pulses. If the byte is '#', go to IDLE; otherwise go to RESYNC.
//   - RESYNC discards bytes until '#', then goes to IDLE.
//   - A valid '#' in HASH copies shadows to angulo/distancia atomically; pronto pulses the next cycle; go to IDLE.
//  Latency: pronto is 1 cycle after the byte_valido of '#'. Outputs never change except on a valid message.
//  Simultaneous: an RX error and a parser error cannot coincide; erro is the OR of both, with one pulse per event.
//  Reset mid-frame: all partial data is discarded and the previous valid outputs are cleared to 0.
//  No overrun is possible: the parser consumes each byte in 1 cycle, and the next byte is >=10 bit times later.
// CONFIGURATION
//  SONAR_RX_PARITY_EN defined: a parity mismatch drops the byte, pulses erro, and sends the parser to RESYNC.
//  SONAR_RX_PARITY_EN undefined: the parity bit is sampled and ignored; the FSM timing is identical.
// STRUCTURE
//  Shared package / include sonar_pkg: ASCII constants (ASCII_ZERO 8'h30, ASCII_VIRG 8'h2C,
//   ASCII_HASH 8'h23) and the parser/RX state encodings, shared with the transmit side.
//  Sub-module rx_serial_7o1: synchroniser, baud counter, RX FSM, odd-parity check.
//   Its outputs are dado[6:0], byte_valido, erro_rx and db_estado.
//  Top contains the parser FSM, shadow registers and output registers.
// TESTING
//  1. reset, send "045,123#" at CLK_DIV=434 -> angulo=12'h045, distancia=12'h123, one pronto pulse, erro never high.
//  2. "180,007#" then "0a0,010#" -> erro on 'a', outputs stay 12'h180/12'h007, no pronto on the second message.
//  3. send 0x35 with stop bit forced 0 -> erro pulse, no byte_valido; then "090,050#" decodes correctly.
//  4. 0.3-bit low glitch on the idle line -> false start: no erro, no byte, db_estado_rx returns to IDLE.
//  5. 0x34 with wrong parity -> with SONAR_RX_PARITY_EN: erro and message dropped;
//     without the macro: message accepted.
//  6. assert reset mid-distance of "120,300#" -> outputs 0 immediately; the next full "120,300#" is accepted.

Source files
------------

// File: rtl/sonar_pkg.sv
// ============================================================================
// Module : sonar_pkg
// Brief  : ASCII constants and FSM state encodings shared by the sonar
//          serial transmit and receive sides.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sonar_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NOVE = 8'h39;
    localparam logic [7:0] ASCII_VIRG = 8'h2C;
    localparam logic [7:0] ASCII_HASH = 8'h23;

    typedef enum logic [3:0] {
        P_IDLE   = 4'h0,
        P_A2     = 4'h1,
        P_A1     = 4'h2,
        P_A0     = 4'h3,
        P_VIRG   = 4'h4,
        P_D2     = 4'h5,
        P_D1     = 4'h6,
        P_D0     = 4'h7,
        P_HASH   = 4'h8,
        P_RESYNC = 4'hF
    } parser_state_t;

    typedef enum logic [3:0] {
        RX_IDLE     = 4'h0,
        RX_START    = 4'h1,
        RX_DADOS    = 4'h2,
        RX_PARIDADE = 4'h3,
        RX_STOP     = 4'h4,
        RX_ESPERA   = 4'h5
    } rx_state_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_ZERO) && (c <= ASCII_NOVE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_serial_7o1.sv
// ============================================================================
// Module : rx_serial_7o1
// Brief  : 7O1 UART receiver: input synchroniser, baud counter, receive FSM
//          and odd-parity check. Parity enforcement: SONAR_RX_PARITY_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_serial_7o1 #(
    parameter int CLK_DIV     = 434,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    output logic [6:0] dado,
    output logic       byte_valido,
    output logic       erro_rx,
    output logic       erro_paridade,
    output logic [3:0] db_estado
);
    import sonar_pkg::*;

`ifdef SONAR_RX_PARITY_EN
    localparam logic c_PARITY_EN = 1'b1;
`else
    localparam logic c_PARITY_EN = 1'b0;
`endif

    localparam int              c_CW   = $clog2(CLK_DIV);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(CLK_DIV - 1);
    localparam logic [c_CW-1:0] c_HALF = c_CW'(CLK_DIV / 2 - 1);

    rx_state_t                r_state;
    rx_state_t                w_next;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     r_rx_prev;
    logic [c_CW-1:0]          r_cnt;
    logic [2:0]               r_bit;
    logic [6:0]               r_shift;
    logic                     r_par;
    logic [6:0]               r_dado;
    logic                     r_byte_valido;
    logic                     r_erro_rx;
    logic                     r_erro_par;
    logic                     w_rx;
    logic                     w_half;
    logic                     w_full;
    logic                     w_par_ok;
    logic                     w_par_bad;

    assign w_rx      = r_sync[SYNC_STAGES-1];
    assign w_half    = (r_cnt == c_HALF);
    assign w_full    = (r_cnt == c_FULL);
    // Odd parity: data plus parity bit must carry an odd number of ones.
    assign w_par_ok  = ^{r_shift, r_par};
    assign w_par_bad = c_PARITY_EN & ~w_par_ok;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= RX_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_IDLE:     if (r_rx_prev && !w_rx) w_next = RX_START;
            RX_START:    if (w_half) w_next = w_rx ? RX_IDLE : RX_DADOS;
            RX_DADOS:    if (w_full && (r_bit == 3'd6)) w_next = RX_PARIDADE;
            RX_PARIDADE: if (w_full) w_next = RX_STOP;
            RX_STOP:     if (w_full) w_next = w_rx ? RX_IDLE : RX_ESPERA;
            RX_ESPERA:   if (w_rx) w_next = RX_IDLE;
            default:     w_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync        <= '1;
            r_rx_prev     <= 1'b1;
            r_cnt         <= '0;
            r_bit         <= '0;
            r_shift       <= '0;
            r_par         <= 1'b0;
            r_dado        <= '0;
            r_byte_valido <= 1'b0;
            r_erro_rx     <= 1'b0;
            r_erro_par    <= 1'b0;
        end else begin
            r_sync        <= {r_sync[SYNC_STAGES-2:0], entrada_serial};
            r_rx_prev     <= w_rx;
            r_byte_valido <= 1'b0;
            r_erro_rx     <= 1'b0;
            r_erro_par    <= 1'b0;

            // The counter restarts on every state change and at each bit boundary.
            if ((r_state != w_next) || w_full)
                r_cnt <= '0;
            else if ((r_state != RX_IDLE) && (r_state != RX_ESPERA))
                r_cnt <= r_cnt + 1'b1;

            if ((r_state == RX_START) && (w_next == RX_DADOS))
                r_bit <= '0;

            if ((r_state == RX_DADOS) && w_full) begin
                r_shift <= {w_rx, r_shift[6:1]};
                r_bit   <= r_bit + 1'b1;
            end

            if ((r_state == RX_PARIDADE) && w_full)
                r_par <= w_rx;

            if ((r_state == RX_STOP) && w_full) begin
                if (!w_rx) begin
                    r_erro_rx <= 1'b1;
                end else if (w_par_bad) begin
                    r_erro_rx  <= 1'b1;
                    r_erro_par <= 1'b1;
                end else begin
                    r_byte_valido <= 1'b1;
                    r_dado        <= r_shift;
                end
            end
        end
    end

    assign dado          = r_dado;
    assign byte_valido   = r_byte_valido;
    assign erro_rx       = r_erro_rx;
    assign erro_paridade = r_erro_par;
    assign db_estado     = r_state;

endmodule

`default_nettype wire

// File: rtl/sonar_rx_decoder.sv
// ============================================================================
// Module : sonar_rx_decoder
// Brief  : Decodes "AAA,DDD#" sonar telemetry from a 7O1 serial line into BCD
//          angle/distance. Optional parity enforcement: SONAR_RX_PARITY_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sonar_rx_decoder #(
    parameter int CLK_DIV     = 434,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [11:0] angulo,
    output logic [11:0] distancia,
    output logic        pronto,
    output logic        erro,
    output logic [3:0]  db_estado,
    output logic [3:0]  db_estado_rx
);
    import sonar_pkg::*;

    logic [6:0]      w_dado;
    logic            w_byte_valido;
    logic            w_erro_rx;
    logic            w_erro_par;
    logic [7:0]      w_byte;
    logic            w_is_digit;
    logic            w_is_virg;
    logic            w_is_hash;

    parser_state_t   r_state;
    parser_state_t   w_next;
    logic            w_bad;
    logic            w_err;
    logic            w_commit;
    logic            w_store_en;
    logic [2:0]      w_store_idx;

    logic [5:0][3:0] r_shadow;
    logic [11:0]     r_angulo;
    logic [11:0]     r_distancia;
    logic            r_pronto;
    logic            r_erro;

    rx_serial_7o1 #(
        .CLK_DIV     (CLK_DIV),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .dado           (w_dado),
        .byte_valido    (w_byte_valido),
        .erro_rx        (w_erro_rx),
        .erro_paridade  (w_erro_par),
        .db_estado      (db_estado_rx)
    );

    assign w_byte     = {1'b0, w_dado};
    assign w_is_digit = is_digit(w_byte);
    assign w_is_virg  = (w_byte == ASCII_VIRG);
    assign w_is_hash  = (w_byte == ASCII_HASH);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= P_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_bad       = 1'b0;
        w_err       = 1'b0;
        w_commit    = 1'b0;
        w_store_en  = 1'b0;
        w_store_idx = 3'd0;
        if (w_erro_par) begin
            w_next = P_RESYNC;
        end else if (w_byte_valido) begin
            case (r_state)
                P_IDLE, P_A2: begin
                    if (w_is_digit) begin w_store_en = 1'b1; w_store_idx = 3'd0; w_next = P_A1; end
                    else w_bad = 1'b1;
                end
                P_A1: begin
                    if (w_is_digit) begin w_store_en = 1'b1; w_store_idx = 3'd1; w_next = P_A0; end
                    else w_bad = 1'b1;
                end
                P_A0: begin
                    if (w_is_digit) begin w_store_en = 1'b1; w_store_idx = 3'd2; w_next = P_VIRG; end
                    else w_bad = 1'b1;
                end
                P_VIRG: begin
                    if (w_is_virg) w_next = P_D2;
                    else w_bad = 1'b1;
                end
                P_D2: begin
                    if (w_is_digit) begin w_store_en = 1'b1; w_store_idx = 3'd3; w_next = P_D1; end
                    else w_bad = 1'b1;
                end
                P_D1: begin
                    if (w_is_digit) begin w_store_en = 1'b1; w_store_idx = 3'd4; w_next = P_D0; end
                    else w_bad = 1'b1;
                end
                P_D0: begin
                    if (w_is_digit) begin w_store_en = 1'b1; w_store_idx = 3'd5; w_next = P_HASH; end
                    else w_bad = 1'b1;
                end
                P_HASH: begin
                    if (w_is_hash) begin w_commit = 1'b1; w_next = P_IDLE; end
                    else w_bad = 1'b1;
                end
                P_RESYNC: if (w_is_hash) w_next = P_IDLE;
                default:  w_next = P_IDLE;
            endcase
            // A stray '#' already marks the start of a fresh message.
            if (w_bad) begin
                w_err  = 1'b1;
                w_next = w_is_hash ? P_IDLE : P_RESYNC;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shadow    <= '0;
            r_angulo    <= '0;
            r_distancia <= '0;
            r_pronto    <= 1'b0;
            r_erro      <= 1'b0;
        end else begin
            // Digits '0'..'9' have their value in the low nibble of the code.
            if (w_store_en)
                r_shadow[w_store_idx] <= w_dado[3:0];
            if (w_commit) begin
                r_angulo    <= {r_shadow[0], r_shadow[1], r_shadow[2]};
                r_distancia <= {r_shadow[3], r_shadow[4], r_shadow[5]};
            end
            r_pronto <= w_commit;
            r_erro   <= w_err | w_erro_rx;
        end
    end

    assign angulo    = r_angulo;
    assign distancia = r_distancia;
    assign pronto    = r_pronto;
    assign erro      = r_erro;
    assign db_estado = r_state;

endmodule

`default_nettype wire
